// File: rtl/sine_dds_core_pkg.sv
// Shared defaults and ROM-content helpers for the sine DDS core.
// The quarter-wave table is computed at elaboration from a short Taylor series.
package sine_dds_core_pkg;

  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 12;

  localparam real PI = 3.14159265358979323846;

  // Offset-binary midpoint, 2^(dw-1).
  function automatic int mid_value(input int dw);
    return 1 << (dw - 1);
  endfunction

  // rom[k] = round((2^(dw-1)-1) * sin(2*pi*(k+0.5)/2^aw)), k in the first quadrant.
  function automatic int rom_entry(input int k, input int aw, input int dw);
    real x;
    real term;
    real s;
    real amp;
    x    = 2.0 * PI * (real'(k) + 0.5) / real'(1 << aw);
    term = x;
    s    = x;
    for (int n = 1; n <= 9; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = real'(mid_value(dw) - 1);
    return $rtoi(amp * s + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a registered (synchronous) read port.
module sine_quarter_rom
  import sine_dds_core_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_WIDTH - 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] table_q [DEPTH];

  // Entries are constant functions of k, so they fold to a ROM at elaboration.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    assign table_q[k] = DATA_WIDTH'(rom_entry(k, ADDR_BITS + 2, DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    data <= table_q[addr];
  end

endmodule

// File: rtl/sine_dds_core.sv
// DDS sine generator: phase accumulator advanced on qualified ticks, quadrant
// fold into a quarter-wave ROM, offset-binary output three cycles after launch.
module sine_dds_core
  import sine_dds_core_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_load,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  output logic                   period_start
);

  localparam int QW = ADDR_WIDTH - 2;
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] ftw_reg;
  logic                   carry_pend;
  logic [PHASE_WIDTH:0]   sum;
  logic                   launch;

  logic [ADDR_WIDTH-1:0]  s1_phase;
  logic                   s1_v;
  logic                   s1_wrap;
  logic [1:0]             quad;
  logic [QW-1:0]          idx;
  logic [QW-1:0]          rom_addr;

  logic                   s2_v;
  logic                   s2_neg;
  logic                   s2_wrap;
  logic [DATA_WIDTH-1:0]  rom_data;

  assign launch = tick & en;
  assign sum    = {1'b0, acc} + {1'b0, ftw_reg};

  // Odd quadrants walk the table backwards; the half-step offset keeps this exact.
  assign quad     = s1_phase[ADDR_WIDTH-1 -: 2];
  assign idx      = s1_phase[QW-1:0];
  assign rom_addr = quad[0] ? ~idx : idx;

  sine_quarter_rom #(
    .ADDR_BITS  (QW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // sample_valid is a one-cycle strobe with no back-pressure; sample holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc          <= '0;
      ftw_reg      <= '0;
      carry_pend   <= 1'b0;
      s1_phase     <= '0;
      s1_v         <= 1'b0;
      s1_wrap      <= 1'b0;
      s2_v         <= 1'b0;
      s2_neg       <= 1'b0;
      s2_wrap      <= 1'b0;
      sample       <= MID;
      sample_valid <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (ftw_load) begin
        ftw_reg <= ftw_in;
      end
      s1_v <= launch;
      if (launch) begin
        s1_phase   <= acc[PHASE_WIDTH-1 -: ADDR_WIDTH];
        s1_wrap    <= carry_pend;
        acc        <= sum[PHASE_WIDTH-1:0];
        carry_pend <= sum[PHASE_WIDTH];
      end
      s2_v         <= s1_v;
      s2_neg       <= quad[1];
      s2_wrap      <= s1_wrap;
      sample_valid <= s2_v;
      period_start <= s2_v & s2_wrap;
      if (s2_v) begin
        sample <= s2_neg ? (MID - rom_data) : (MID + rom_data);
      end
    end
  end

endmodule

// File: tb/tb_sine_dds_core.sv
// Scoreboard bench for sine_dds_core: a phase/carry model pushes expected
// samples at each launch edge, and a negedge monitor pops and compares them.
module tb_sine_dds_core;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        en;
  logic [31:0] ftw_in;
  logic        ftw_load;
  logic [11:0] sample;
  logic        sample_valid;
  logic        period_start;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rec_q[$];
  logic         rec_on  = 1'b0;
  logic         mon_on  = 1'b0;
  logic [11:0]  last_exp = 12'd2048;
  int           first_valid_cyc = -1;

  logic [31:0]  acc_m;
  logic [31:0]  ftw_m;
  logic         cp_m;

  sine_dds_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .en           (en),
    .ftw_in       (ftw_in),
    .ftw_load     (ftw_load),
    .sample       (sample),
    .sample_valid (sample_valid),
    .period_start (period_start)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_sample(input logic [7:0] ph);
    real a;
    int  r;
    a = $sin(2.0 * 3.14159265358979 * (real'(ph) + 0.5) / 256.0);
    if (a < 0.0) a = -a;
    r = $rtoi(2047.0 * a + 0.5);
    return ph[7] ? 12'(2048 - r) : 12'(2048 + r);
  endfunction

  // ---------------- reference model, evaluated at each edge ----------------
  task automatic model_edge(input logic r, input logic launch, input logic ld, input logic [31:0] f);
    logic [32:0] s;
    if (!r) begin
      acc_m    = '0;
      ftw_m    = '0;
      cp_m     = 1'b0;
      last_exp = 12'd2048;
      exp_q.delete();
    end else begin
      if (launch) begin
        exp_q.push_back({cp_m, exp_sample(acc_m[31:24])});
        s     = {1'b0, acc_m} + {1'b0, ftw_m};
        acc_m = s[31:0];
        cp_m  = s[32];
      end
      if (ld) ftw_m = f;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic t, input logic e, input logic ld, input logic [31:0] f);
    rst_n    = r;
    tick     = t;
    en       = e;
    ftw_load = ld;
    ftw_in   = f;
    @(posedge clk);
    model_edge(r, t & e, ld, f);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_on) begin
      if (sample_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rec_on) rec_q.push_back({period_start, sample});
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(sample_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sample", 32'(sample), 32'(e[11:0]));
          check("period_start", 32'(period_start), 32'(e[12]));
          last_exp = e[11:0];
        end
      end else begin
        check("hold", 32'(sample), 32'(last_exp));
        check("stray_period_start", 32'(period_start), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int launch_cyc;
    int nv;

    // Reset and first samples at ftw = 2^24.
    do_reset();
    mon_on = 1'b1;
    @(negedge clk);
    check("reset_sample", 32'(sample), 32'd2048);
    check("reset_valid", 32'(sample_valid), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0100_0000);
    rec_q.delete();
    rec_on = 1'b1;
    first_valid_cyc = -1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    launch_cyc = cyc;
    for (int i = 0; i < 259; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(4);
    check("first_latency", 32'(first_valid_cyc - launch_cyc), 32'd2);
    check("full_count", 32'(rec_q.size()), 32'd260);
    check("first_sample", 32'(rec_q[0]), 32'd2073);
    check("second_sample", 32'(rec_q[1]), 32'd2123);
    check("peak_63", 32'(rec_q[63][11:0]), 32'd4095);
    check("peak_64", 32'(rec_q[64][11:0]), 32'd4095);
    check("min_191", 32'(rec_q[191][11:0]), 32'd1);
    check("min_192", 32'(rec_q[192][11:0]), 32'd1);
    for (int k = 0; k < 128; k++)
      check("symmetry", 32'(rec_q[128+k][11:0]) + 32'(rec_q[k][11:0]), 32'd4096);
    check("wrap_255", 32'(rec_q[255][12]), 32'd0);
    check("wrap_256", 32'(rec_q[256][12]), 32'd1);

    // Half-rate tuning word: alternating samples, wrap on every other one.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
    rec_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(4);
    check("half_count", 32'(rec_q.size()), 32'd8);
    check("half_0", 32'(rec_q[0]), {19'd0, 1'b0, 12'd2073});
    check("half_1", 32'(rec_q[1]), {19'd0, 1'b0, 12'd2023});
    check("half_2", 32'(rec_q[2]), {19'd0, 1'b1, 12'd2073});
    check("half_3", 32'(rec_q[3]), {19'd0, 1'b0, 12'd2023});
    check("half_6", 32'(rec_q[6]), {19'd0, 1'b1, 12'd2073});

    // Tick every 10 cycles, then en low across 5 ticks, then resume.
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0100_0000);
    rec_q.delete();
    for (int i = 0; i < 100; i++) step(1'b1, (i % 10) == 9, 1'b1, 1'b0, 32'd0);
    idle(3);
    check("tick10_count", 32'(rec_q.size()), 32'd10);
    for (int i = 0; i < 50; i++) step(1'b1, (i % 10) == 9, 1'b0, 1'b0, 32'd0);
    check("en_low_count", 32'(rec_q.size()), 32'd10);
    for (int i = 0; i < 30; i++) step(1'b1, (i % 10) == 9, 1'b1, 1'b0, 32'd0);
    idle(3);
    check("resume_count", 32'(rec_q.size()), 32'd13);

    // FTW load colliding with a launch: that step still uses the old word.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0100_0000);
    rec_q.delete();
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0200_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(4);
    check("collide_count", 32'(rec_q.size()), 32'd5);
    check("collide_ph2", 32'(rec_q[2][11:0]), 32'(exp_sample(8'd2)));
    check("collide_ph3", 32'(rec_q[3][11:0]), 32'(exp_sample(8'd3)));
    check("collide_ph5", 32'(rec_q[4][11:0]), 32'(exp_sample(8'd5)));

    // Mid-run reset with samples in flight, then run without reloading.
    rec_q.delete();
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(5);
    check("flush_count", 32'(rec_q.size()), 32'd0);
    check("flush_sample", 32'(sample), 32'd2048);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(4);
    nv = rec_q.size();
    check("zero_ftw_count", 32'(nv), 32'd4);
    for (int k = 0; k < 4; k++)
      check("zero_ftw_sample", 32'(rec_q[k]), {19'd0, 1'b0, 12'd2073});

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
